// File: rtl/fp_issue_pkg.sv
// Shared types for the FP issue/writeback scheduler: op classes, writeback
// mux selects, div FSM states and the per-slot writeback metadata.
package fp_issue_pkg;

  localparam logic [1:0] FP_CLS_FAST = 2'd0;
  localparam logic [1:0] FP_CLS_FMA  = 2'd1;
  localparam logic [1:0] FP_CLS_DIV  = 2'd2;
  localparam logic [1:0] FP_CLS_ILL  = 2'd3;

  localparam logic [1:0] FP_WB_FAST  = 2'd0;
  localparam logic [1:0] FP_WB_FMA   = 2'd1;
  localparam logic [1:0] FP_WB_DIV   = 2'd2;

  typedef enum logic [1:0] {
    DIV_IDLE,
    DIV_BUSY,
    DIV_HOLD
  } fp_div_state_type;

  typedef struct packed {
    logic [1:0] src;
    logic       ill;
  } fp_slot_meta_t;

  // Illegal ops ride the fast path but carry the exception flag instead of data.
  function automatic fp_slot_meta_t fp_fast_meta(input logic [1:0] cls);
    fp_slot_meta_t m;
    m.src = FP_WB_FAST;
    m.ill = (cls == FP_CLS_ILL);
    return m;
  endfunction

endpackage

// File: rtl/fp_issue_if.sv
// Request / issue / writeback bundle between the FP issue scheduler and its
// surroundings; slave is the scheduler, master the requester and datapath side.
interface fp_issue_if #(
  parameter int TAG_W = 5
);
  logic             req_valid;
  logic             req_ready;
  logic [1:0]       req_class;
  logic [TAG_W-1:0] req_tag;
  logic             flush;
  logic             iss_fast;
  logic             iss_fma;
  logic             iss_div;
  logic             div_done;
  logic             div_kill;
  logic             wb_valid;
  logic [TAG_W-1:0] wb_tag;
  logic [1:0]       wb_src;
  logic             wb_ill;
  logic             busy;

  modport master (
    output req_valid, req_class, req_tag, flush, div_done,
    input  req_ready, iss_fast, iss_fma, iss_div, div_kill,
           wb_valid, wb_tag, wb_src, wb_ill, busy
  );

  modport slave (
    input  req_valid, req_class, req_tag, flush, div_done,
    output req_ready, iss_fast, iss_fma, iss_div, div_kill,
           wb_valid, wb_tag, wb_src, wb_ill, busy
  );
endinterface

// File: rtl/fp_wb_slots.sv
// Writeback slot shift register: slot k holds the result due k cycles from now.
// Latency 1 from set_bot, FMA_LAT from set_top; flush clears every valid bit.
module fp_wb_slots
  import fp_issue_pkg::*;
#(
  parameter int FMA_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               flush,
  input  logic               set_bot,
  input  logic [TAG_W-1:0]   bot_tag,
  input  fp_slot_meta_t      bot_meta,
  input  logic               set_top,
  input  logic [TAG_W-1:0]   top_tag,
  output logic [FMA_LAT-1:0] v,
  output logic [TAG_W-1:0]   tag0,
  output fp_slot_meta_t      meta0
);
  logic [TAG_W-1:0] tag_q  [FMA_LAT];
  fp_slot_meta_t    meta_q [FMA_LAT];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      v <= '0;
      for (int k = 0; k < FMA_LAT; k++) begin
        tag_q[k]  <= '0;
        meta_q[k] <= '0;
      end
    end else if (flush) begin
      v <= '0;
    end else begin
      for (int k = 0; k < FMA_LAT - 1; k++) begin
        v[k]      <= v[k+1];
        tag_q[k]  <= tag_q[k+1];
        meta_q[k] <= meta_q[k+1];
      end
      v[FMA_LAT-1] <= 1'b0;
      // Inserts land after the shift, so they override the shifted-in entry.
      if (set_top) begin
        v[FMA_LAT-1]      <= 1'b1;
        tag_q[FMA_LAT-1]  <= top_tag;
        meta_q[FMA_LAT-1] <= '{src: FP_WB_FMA, ill: 1'b0};
      end
      if (set_bot) begin
        v[0]      <= 1'b1;
        tag_q[0]  <= bot_tag;
        meta_q[0] <= bot_meta;
      end
    end
  end

  assign tag0  = tag_q[0];
  assign meta0 = meta_q[0];
endmodule

// File: rtl/fp_issue.sv
// FP issue/writeback scheduler: wb 1 cycle after fast/illegal accept, FMA_LAT after FMA, div when a slot frees.
// Backpressure: req_ready drops on slot-1 conflict, div busy, div result held, flush or reset.
module fp_issue
  import fp_issue_pkg::*;
#(
  parameter int FMA_LAT = 3,
  parameter int TAG_W   = 5
) (
  input  logic      clock,
  input  logic      reset,
  fp_issue_if.slave io
);
  fp_div_state_type   dstate, dstate_nxt;
  logic [TAG_W-1:0]   div_tag;
  logic [FMA_LAT-1:0] v;
  logic [TAG_W-1:0]   slot_tag;
  fp_slot_meta_t      slot_meta;
  logic               cls_ok;
  logic               accept;
  logic               hold_wb;

  always_comb begin
    cls_ok = 1'b0;
    case (io.req_class)
      FP_CLS_FAST, FP_CLS_ILL: cls_ok = !v[1];
      FP_CLS_FMA:              cls_ok = 1'b1;
      default:                 cls_ok = (dstate == DIV_IDLE);
    endcase
  end

  // HOLD refuses everything so the slots drain and the div result cannot starve.
  assign io.req_ready = !reset && !io.flush && (dstate != DIV_HOLD) && cls_ok;
  assign accept       = io.req_valid && io.req_ready;
  assign io.iss_fast  = accept && (io.req_class == FP_CLS_FAST);
  assign io.iss_fma   = accept && (io.req_class == FP_CLS_FMA);
  assign io.iss_div   = accept && (io.req_class == FP_CLS_DIV);

  fp_wb_slots #(
    .FMA_LAT (FMA_LAT),
    .TAG_W   (TAG_W)
  ) u_slots (
    .clock    (clock),
    .reset    (reset),
    .flush    (io.flush),
    .set_bot  (accept && ((io.req_class == FP_CLS_FAST) || (io.req_class == FP_CLS_ILL))),
    .bot_tag  (io.req_tag),
    .bot_meta (fp_fast_meta(io.req_class)),
    .set_top  (io.iss_fma),
    .top_tag  (io.req_tag),
    .v        (v),
    .tag0     (slot_tag),
    .meta0    (slot_meta)
  );

  always_comb begin
    dstate_nxt = dstate;
    if (io.flush) begin
      dstate_nxt = DIV_IDLE;
    end else begin
      case (dstate)
        DIV_IDLE: if (io.iss_div)  dstate_nxt = DIV_BUSY;
        DIV_BUSY: if (io.div_done) dstate_nxt = DIV_HOLD;
        DIV_HOLD: if (!v[0])       dstate_nxt = DIV_IDLE;
        default:                   dstate_nxt = DIV_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      dstate  <= DIV_IDLE;
      div_tag <= '0;
    end else begin
      dstate <= dstate_nxt;
      if (io.iss_div) div_tag <= io.req_tag;
    end
  end

  // A held div result is dropped, not written back, when flush arrives.
  assign hold_wb     = (dstate == DIV_HOLD) && !v[0] && !io.flush;
  assign io.wb_valid = v[0] || hold_wb;
  assign io.wb_tag   = v[0] ? slot_tag      : (hold_wb ? div_tag   : '0);
  assign io.wb_src   = v[0] ? slot_meta.src : (hold_wb ? FP_WB_DIV : FP_WB_FAST);
  assign io.wb_ill   = v[0] && slot_meta.ill;
  assign io.div_kill = io.flush && (dstate != DIV_IDLE);
  assign io.busy     = (|v) || (dstate != DIV_IDLE);
endmodule

// File: tb/tb_fp_issue.sv
// Bench for fp_issue: writeback-timeline model checked every cycle plus directed literal checks.
module tb_fp_issue;
  import fp_issue_pkg::*;

  localparam int LAT = 3;

  logic clock;
  logic reset;
  int   n_chk = 0;
  int   n_err = 0;
  int   t     = 0;

  fp_issue_if #(.TAG_W(5)) bus ();

  fp_issue #(.FMA_LAT(LAT), .TAG_W(5)) dut (
    .clock (clock),
    .reset (reset),
    .io    (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, t);
    end
  endtask

  // Model: timeline of writebacks due at absolute cycles (mod 16) plus div phase.
  typedef struct {
    logic [4:0] tag;
    logic [1:0] src;
    logic       ill;
  } ev_t;

  bit         due_v [16];
  ev_t        due_e [16];
  int         m_div;     // 0 none, 1 running, 2 result held
  logic [4:0] m_tag;
  bit         cls_ok, e_rdy, acc, e_wbv, e_busy;
  ev_t        ev;
  int         s0, s1;

  always @(negedge clock) begin
    s0 = t % 16;
    s1 = (t + 1) % 16;
    if (reset) begin
      for (int k = 0; k < 16; k++) due_v[k] = 1'b0;
      m_div = 0;
      chk("rst_req_ready", bus.req_ready, 0);
      chk("rst_iss", {bus.iss_fast, bus.iss_fma, bus.iss_div, bus.div_kill}, 0);
      chk("rst_wb", {bus.wb_valid, bus.wb_tag, bus.wb_src, bus.wb_ill}, 0);
      chk("rst_busy", bus.busy, 0);
    end else begin
      case (bus.req_class)
        FP_CLS_FAST, FP_CLS_ILL: cls_ok = !due_v[s1];
        FP_CLS_FMA:              cls_ok = 1'b1;
        default:                 cls_ok = (m_div == 0);
      endcase
      e_rdy = !bus.flush && (m_div != 2) && cls_ok;
      acc   = bus.req_valid && e_rdy;
      e_wbv = due_v[s0] || (m_div == 2 && !bus.flush);
      if (due_v[s0]) ev = due_e[s0];
      else begin
        ev.tag = m_tag; ev.src = FP_WB_DIV; ev.ill = 1'b0;
      end
      e_busy = (m_div != 0);
      for (int k = 0; k < 16; k++) if (due_v[k]) e_busy = 1'b1;

      chk("m_req_ready", bus.req_ready, e_rdy);
      chk("m_iss_fast", bus.iss_fast, acc && bus.req_class == FP_CLS_FAST);
      chk("m_iss_fma", bus.iss_fma, acc && bus.req_class == FP_CLS_FMA);
      chk("m_iss_div", bus.iss_div, acc && bus.req_class == FP_CLS_DIV);
      chk("m_div_kill", bus.div_kill, bus.flush && m_div != 0);
      chk("m_wb_valid", bus.wb_valid, e_wbv);
      if (e_wbv) chk("m_wb_fields", {bus.wb_tag, bus.wb_src, bus.wb_ill}, {ev.tag, ev.src, ev.ill});
      chk("m_busy", bus.busy, e_busy);

      if (bus.flush) begin
        for (int k = 0; k < 16; k++) due_v[k] = 1'b0;
        m_div = 0;
      end else begin
        if (m_div == 1 && bus.div_done) m_div = 2;
        else if (m_div == 2 && !due_v[s0]) m_div = 0;
        if (acc) begin
          if (bus.req_class == FP_CLS_FMA) begin
            due_v[(t + LAT) % 16] = 1'b1;
            due_e[(t + LAT) % 16] = '{tag: bus.req_tag, src: FP_WB_FMA, ill: 1'b0};
          end else if (bus.req_class == FP_CLS_DIV) begin
            m_div = 1;
            m_tag = bus.req_tag;
          end else begin
            due_v[s1] = 1'b1;
            due_e[s1] = '{tag: bus.req_tag, src: FP_WB_FAST, ill: (bus.req_class == FP_CLS_ILL)};
          end
        end
        due_v[s0] = 1'b0;
      end
    end
    t++;
  end

  // One cycle of stimulus; returns 3 time units after the edge for literal checks.
  task automatic cyc(input bit vld, input logic [1:0] cls, input logic [4:0] tg,
                     input bit dd, input bit fl);
    @(posedge clock);
    #1;
    bus.req_valid = vld;
    bus.req_class = cls;
    bus.req_tag   = tg;
    bus.div_done  = dd;
    bus.flush     = fl;
    #2;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(1'b0, FP_CLS_FAST, 5'd0, 1'b0, 1'b0);
  endtask

  initial begin
    reset = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_class = FP_CLS_FAST;
    bus.req_tag   = 5'd1;
    bus.flush     = 1'b0;
    bus.div_done  = 1'b0;
    #12;
    chk("reset_ready", bus.req_ready, 0);
    chk("reset_iss_fast", bus.iss_fast, 0);
    chk("reset_wb_valid", bus.wb_valid, 0);
    chk("reset_busy", bus.busy, 0);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    idle(2);

    // Single fast op
    cyc(1, FP_CLS_FAST, 5'd5, 0, 0);
    chk("fast_iss", bus.iss_fast, 1);
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("fast_wb", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd5, FP_WB_FAST});
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("fast_idle", {bus.busy, bus.wb_valid}, 0);
    idle(2);

    // FMA then fast ops contending for the slot the FMA owns
    cyc(1, FP_CLS_FMA, 5'd1, 0, 0);
    chk("fma_iss", bus.iss_fma, 1);
    cyc(1, FP_CLS_FAST, 5'd2, 0, 0);
    chk("fast2_accept", {bus.req_ready, bus.iss_fast}, 2'b11);
    cyc(1, FP_CLS_FAST, 5'd3, 0, 0);
    chk("fast3_refused", {bus.req_ready, bus.iss_fast}, 2'b00);
    chk("wb_tag2", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd2, FP_WB_FAST});
    cyc(1, FP_CLS_FAST, 5'd3, 0, 0);
    chk("fast3_accept", bus.iss_fast, 1);
    chk("wb_tag1_fma", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd1, FP_WB_FMA});
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("wb_tag3", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd3, FP_WB_FAST});
    idle(3);

    // Div with result held behind an FMA
    cyc(1, FP_CLS_DIV, 5'd9, 0, 0);
    chk("div_iss", bus.iss_div, 1);
    cyc(1, FP_CLS_DIV, 5'd10, 0, 0);
    chk("div2_refused", {bus.req_ready, bus.iss_div, bus.busy}, 3'b001);
    cyc(1, FP_CLS_FAST, 5'd11, 0, 0);
    chk("fast_during_div", bus.iss_fast, 1);
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("wb_tag11", {bus.wb_valid, bus.wb_tag}, {1'b1, 5'd11});
    idle(5);
    cyc(1, FP_CLS_FMA, 5'd4, 0, 0);
    chk("fma4_iss", bus.iss_fma, 1);
    cyc(0, FP_CLS_FAST, 5'd0, 1, 0);
    chk("div_done_nowb", bus.wb_valid, 0);
    cyc(1, FP_CLS_FAST, 5'd12, 0, 0);
    chk("hold_refuses", bus.req_ready, 0);
    chk("wb_div9", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd9, FP_WB_DIV});
    cyc(1, FP_CLS_FAST, 5'd12, 0, 0);
    chk("after_hold_ready", bus.req_ready, 1);
    chk("wb_fma4", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd4, FP_WB_FMA});
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("wb_tag12", {bus.wb_valid, bus.wb_tag}, {1'b1, 5'd12});

    // div_done coinciding with an FMA writeback in slot 0
    cyc(1, FP_CLS_DIV, 5'd20, 0, 0);
    cyc(1, FP_CLS_FMA, 5'd21, 0, 0);
    idle(2);
    cyc(0, FP_CLS_FAST, 5'd0, 1, 0);
    chk("coincide_fma", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd21, FP_WB_FMA});
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("coincide_div", {bus.wb_valid, bus.wb_tag, bus.wb_src}, {1'b1, 5'd20, FP_WB_DIV});
    cyc(0, FP_CLS_FAST, 5'd0, 1, 0);
    chk("idle_done_ignored", bus.busy, 0);
    idle(2);

    // Illegal op
    cyc(1, FP_CLS_ILL, 5'd7, 0, 0);
    chk("ill_no_iss", {bus.req_ready, bus.iss_fast, bus.iss_fma, bus.iss_div}, 4'b1000);
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("ill_wb", {bus.wb_valid, bus.wb_ill, bus.wb_tag, bus.wb_src}, {1'b1, 1'b1, 5'd7, FP_WB_FAST});
    idle(2);

    // Flush with div busy and FMA in flight
    cyc(1, FP_CLS_DIV, 5'd9, 0, 0);
    idle(3);
    cyc(1, FP_CLS_FMA, 5'd6, 0, 0);
    cyc(1, FP_CLS_FAST, 5'd3, 0, 1);
    chk("flush_refuse", {bus.req_ready, bus.iss_fast}, 0);
    chk("flush_kill", bus.div_kill, 1);
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("post_flush", {bus.wb_valid, bus.busy, bus.div_kill}, 0);
    cyc(0, FP_CLS_FAST, 5'd0, 1, 0);
    chk("post_flush_nowb", bus.wb_valid, 0);
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("post_flush_idle", bus.busy, 0);
    idle(2);

    // Asynchronous reset in the middle of a div
    cyc(1, FP_CLS_DIV, 5'd3, 0, 0);
    cyc(1, FP_CLS_FAST, 5'd8, 0, 0);
    chk("pre_reset_iss", bus.iss_fast, 1);
    reset = 1'b1;
    #1;
    chk("mid_reset_out", {bus.req_ready, bus.iss_fast, bus.wb_valid, bus.busy, bus.div_kill}, 0);
    @(posedge clock);
    @(posedge clock);
    #1;
    reset = 1'b0;
    bus.req_valid = 1'b0;
    cyc(1, FP_CLS_FAST, 5'd8, 0, 0);
    chk("after_reset_iss", bus.iss_fast, 1);
    cyc(0, FP_CLS_FAST, 5'd0, 0, 0);
    chk("after_reset_wb", {bus.wb_valid, bus.wb_tag}, {1'b1, 5'd8});
    idle(2);

    // Mixed traffic, checked by the model only
    for (int i = 0; i < 400; i++) begin
      cyc(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 5'($urandom_range(0, 31)),
          ($urandom_range(0, 5) == 0), ($urandom_range(0, 40) == 0));
    end
    idle(12);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
